axil_reg_slave: RTL and testbench

Parametrised AXI-Lite slave endpoint that terminates one AXI-Lite port, for example the output of the AXI-to-AXI-Lite bridge. It exposes a bank of NUM_REGS registers with byte strobes, per-register read-only mask, address-range checking with SLVERR, and independent AW/W acceptance. It serves as both a real register bank and a reference target for the VIP scoreboard.

---
 rtl/axil_pkg.sv | 31 +++
 rtl/axil_addr_decode.sv | 28 ++
 rtl/axil_reg_slave.sv | 199 +++++++++++++++++++
 tb/tb_axil_reg_slave.sv | 547 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared AXI-Lite types and helpers for the register slave.
// Response codes, strobe shift and byte-merge function.
package axil_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_t;

   // Address bits below the word offset.
   function automatic int strb_shift(input int strb_w);
      return $clog2(strb_w);
   endfunction

   // Byte-wise merge sized for the widest legal bus (64 bits).
   function automatic logic [63:0] apply_wstrb(
      input logic [63:0] old,
      input logic [63:0] nw,
      input logic [7:0]  strb
   );
      logic [63:0] r;
      r = old;
      for (int b = 0; b < 8; b++) begin
         if (strb[b]) r[b*8 +: 8] = nw[b*8 +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/axil_addr_decode.sv
// Combinational byte address to register index decode.
// Low offset bits are dropped; hit flags an in-range access.
module axil_addr_decode
   import axil_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    STRB_WIDTH = 4,
   parameter int                    NUM_REGS   = 16,
   parameter int                    IDX_W      = 4,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic [IDX_W-1:0]      idx,
   output logic                  hit
);

   localparam int SHIFT = strb_shift(STRB_WIDTH);

   logic [ADDR_WIDTH-1:0] off;
   logic [ADDR_WIDTH-1:0] word;

   assign off  = addr - BASE_ADDR;
   assign word = off >> SHIFT;
   assign idx  = word[IDX_W-1:0];
   assign hit  = (addr >= BASE_ADDR) &&
                 (word < ADDR_WIDTH'(NUM_REGS));

endmodule

// File: rtl/axil_reg_slave.sv
// AXI-Lite register bank slave with byte strobes, RO mask
// and SLVERR on out-of-range accesses.
module axil_reg_slave
   import axil_pkg::*;
#(
   parameter int ADDR_WIDTH      = 32,
   parameter int AXIL_DATA_WIDTH = 32,
   parameter int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8,
   parameter int NUM_REGS        = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
   parameter logic [NUM_REGS-1:0]   RO_MASK   = '0,
   parameter logic [NUM_REGS*AXIL_DATA_WIDTH-1:0]
                                    RESET_VAL = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [ADDR_WIDTH-1:0]      s_axil_awaddr,
   input  logic [2:0]                 s_axil_awprot,
   input  logic                       s_axil_awvalid,
   output logic                       s_axil_awready,
   input  logic [AXIL_DATA_WIDTH-1:0] s_axil_wdata,
   input  logic [AXIL_STRB_WIDTH-1:0] s_axil_wstrb,
   input  logic                       s_axil_wvalid,
   output logic                       s_axil_wready,
   output logic [1:0]                 s_axil_bresp,
   output logic                       s_axil_bvalid,
   input  logic                       s_axil_bready,
   input  logic [ADDR_WIDTH-1:0]      s_axil_araddr,
   input  logic [2:0]                 s_axil_arprot,
   input  logic                       s_axil_arvalid,
   output logic                       s_axil_arready,
   output logic [AXIL_DATA_WIDTH-1:0] s_axil_rdata,
   output logic [1:0]                 s_axil_rresp,
   output logic                       s_axil_rvalid,
   input  logic                       s_axil_rready,
   output logic [NUM_REGS*AXIL_DATA_WIDTH-1:0] reg_q,
   input  logic [NUM_REGS*AXIL_DATA_WIDTH-1:0] hw_in,
   output logic [NUM_REGS-1:0]        wr_pulse
);

   localparam int DW    = AXIL_DATA_WIDTH;
   localparam int SW    = AXIL_STRB_WIDTH;
   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   logic                  aw_held;
   logic                  w_held;
   logic [ADDR_WIDTH-1:0] awaddr_q;
   logic [DW-1:0]         wdata_q;
   logic [SW-1:0]         wstrb_q;
   logic [IDX_W-1:0]      aw_idx;
   logic                  aw_hit;
   logic [IDX_W-1:0]      ar_idx;
   logic                  ar_hit;
   logic                  commit;
   logic                  wr_en;
   logic                  ar_hs;
   logic [DW-1:0]         rd_val;
   logic [DW-1:0]         regs [NUM_REGS];
   logic [DW-1:0]         hw   [NUM_REGS];
   logic                  unused_prot;

   assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

   axil_addr_decode #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .STRB_WIDTH (SW),
      .NUM_REGS   (NUM_REGS),
      .IDX_W      (IDX_W),
      .BASE_ADDR  (BASE_ADDR)
   ) u_aw_dec (
      .addr (awaddr_q),
      .idx  (aw_idx),
      .hit  (aw_hit)
   );

   axil_addr_decode #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .STRB_WIDTH (SW),
      .NUM_REGS   (NUM_REGS),
      .IDX_W      (IDX_W),
      .BASE_ADDR  (BASE_ADDR)
   ) u_ar_dec (
      .addr (s_axil_araddr),
      .idx  (ar_idx),
      .hit  (ar_hit)
   );

   assign s_axil_awready = !aw_held;
   assign s_axil_wready  = !w_held;
   assign s_axil_arready = !s_axil_rvalid || s_axil_rready;

   assign commit = aw_held && w_held &&
                   (!s_axil_bvalid || s_axil_bready);
   assign wr_en  = commit && aw_hit && !RO_MASK[aw_idx];
   assign ar_hs  = s_axil_arvalid && s_axil_arready;

   // Hold the write address until it is committed.
   always_ff @(posedge clk) begin
      if (rst) begin
         aw_held  <= 1'b0;
         awaddr_q <= '0;
      end else if (commit) begin
         aw_held <= 1'b0;
      end else if (s_axil_awvalid && s_axil_awready) begin
         aw_held  <= 1'b1;
         awaddr_q <= s_axil_awaddr;
      end
   end

   // Hold the write data and strobes until committed.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_held  <= 1'b0;
         wdata_q <= '0;
         wstrb_q <= '0;
      end else if (commit) begin
         w_held <= 1'b0;
      end else if (s_axil_wvalid && s_axil_wready) begin
         w_held  <= 1'b1;
         wdata_q <= s_axil_wdata;
         wstrb_q <= s_axil_wstrb;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         assign reg_q[gi*DW +: DW] = regs[gi];
         assign hw[gi] = hw_in[gi*DW +: DW];
         if (RO_MASK[gi]) begin : g_ro
            // Read-only slot keeps its reset value.
            always_ff @(posedge clk) begin
               if (rst) regs[gi] <= RESET_VAL[gi*DW +: DW];
            end
         end else begin : g_rw
            // Byte-strobed update on a committed hit.
            always_ff @(posedge clk) begin
               if (rst) begin
                  regs[gi] <= RESET_VAL[gi*DW +: DW];
               end else if (wr_en &&
                            aw_idx == IDX_W'(gi)) begin
                  regs[gi] <= DW'(apply_wstrb(
                     64'(regs[gi]),
                     64'(wdata_q),
                     8'(wstrb_q)));
               end
            end
         end
      end
   endgenerate

   // Write response; a new commit may replace a consumed one.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_axil_bvalid <= 1'b0;
         s_axil_bresp  <= RESP_OKAY;
      end else if (commit) begin
         s_axil_bvalid <= 1'b1;
         s_axil_bresp  <= aw_hit ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axil_bready) begin
         s_axil_bvalid <= 1'b0;
      end
   end

   // One-cycle strobe for the register just written.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_pulse <= '0;
      end else begin
         wr_pulse <= '0;
         if (wr_en) wr_pulse[aw_idx] <= 1'b1;
      end
   end

   // Read source selection; misses return zero.
   always_comb begin
      rd_val = '0;
      if (ar_hit) begin
         if (RO_MASK[ar_idx]) rd_val = hw[ar_idx];
         else                 rd_val = regs[ar_idx];
      end
   end

   // Read response register, held until accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_axil_rvalid <= 1'b0;
         s_axil_rdata  <= '0;
         s_axil_rresp  <= RESP_OKAY;
      end else if (ar_hs) begin
         s_axil_rvalid <= 1'b1;
         s_axil_rdata  <= rd_val;
         s_axil_rresp  <= ar_hit ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axil_rready) begin
         s_axil_rvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Self-checking bench for axil_reg_slave.
// Randomized traffic is compared with a byte-level register model.
module tb_axil_reg_slave;

   localparam int NR = 16;
   localparam int DW = 32;
   localparam logic [NR-1:0] RO = 16'h0008;

   function automatic logic [NR*DW-1:0] make_rv();
      logic [NR*DW-1:0] r;
      for (int i = 0; i < NR; i++)
         r[i*DW +: DW] = 32'h0100_0000 * i + 32'h55;
      return r;
   endfunction

   localparam logic [NR*DW-1:0] RV = make_rv();

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   awaddr;
   logic [2:0]    awprot;
   logic          awvalid;
   logic          awready;
   logic [31:0]   wdata;
   logic [3:0]    wstrb;
   logic          wvalid;
   logic          wready;
   logic [1:0]    bresp;
   logic          bvalid;
   logic          bready;
   logic [31:0]   araddr;
   logic [2:0]    arprot;
   logic          arvalid;
   logic          arready;
   logic [31:0]   rdata;
   logic [1:0]    rresp;
   logic          rvalid;
   logic          rready;
   logic [NR*DW-1:0] reg_q;
   logic [NR*DW-1:0] hw;
   logic [NR-1:0] wr_pulse;

   int errors = 0;
   int checks = 0;
   logic [31:0] mdl [NR];

   always #5 clk = ~clk;

   axil_reg_slave #(
      .ADDR_WIDTH      (32),
      .AXIL_DATA_WIDTH (DW),
      .NUM_REGS        (NR),
      .BASE_ADDR       (32'h0),
      .RO_MASK         (RO),
      .RESET_VAL       (RV)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .s_axil_awaddr  (awaddr),
      .s_axil_awprot  (awprot),
      .s_axil_awvalid (awvalid),
      .s_axil_awready (awready),
      .s_axil_wdata   (wdata),
      .s_axil_wstrb   (wstrb),
      .s_axil_wvalid  (wvalid),
      .s_axil_wready  (wready),
      .s_axil_bresp   (bresp),
      .s_axil_bvalid  (bvalid),
      .s_axil_bready  (bready),
      .s_axil_araddr  (araddr),
      .s_axil_arprot  (arprot),
      .s_axil_arvalid (arvalid),
      .s_axil_arready (arready),
      .s_axil_rdata   (rdata),
      .s_axil_rresp   (rresp),
      .s_axil_rvalid  (rvalid),
      .s_axil_rready  (rready),
      .reg_q          (reg_q),
      .hw_in          (hw),
      .wr_pulse       (wr_pulse)
   );

   // ---------------- reference model ----------------
   task automatic m_reset();
      logic [NR*DW-1:0] rv;
      rv = RV;
      for (int i = 0; i < NR; i++) mdl[i] = rv[i*DW +: DW];
   endtask

   function automatic logic [NR*DW-1:0] m_flat();
      logic [NR*DW-1:0] f;
      for (int i = 0; i < NR; i++) f[i*DW +: DW] = mdl[i];
      return f;
   endfunction

   task automatic m_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] resp,
                          output logic [NR-1:0] pulse);
      int idx;
      pulse = '0;
      resp  = 2'b00;
      if (a >= NR * 4) begin
         resp = 2'b10;
      end else begin
         idx = int'(a / 4);
         if (!RO[idx]) begin
            for (int b = 0; b < 4; b++)
               if (s[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
            pulse[idx] = 1'b1;
         end
      end
   endtask

   task automatic m_read(input logic [31:0] a, output logic [31:0] d,
                         output logic [1:0] resp);
      int idx;
      if (a >= NR * 4) begin
         d = 32'h0;
         resp = 2'b10;
      end else begin
         idx = int'(a / 4);
         d = RO[idx] ? hw[idx*DW +: DW] : mdl[idx];
         resp = 2'b00;
      end
   endtask

   // ---------------- bus drivers ----------------
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      awvalid = 1'b0;
      wvalid = 1'b0;
      arvalid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_reset();
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic bv1,
                     output logic bv2, output logic [1:0] br,
                     output logic [NR-1:0] p2, output logic [NR-1:0] p3);
      @(negedge clk);
      awaddr = a;
      wdata = d;
      wstrb = s;
      awvalid = 1'b1;
      wvalid = 1'b1;
      bready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      awvalid = 1'b0;
      wvalid = 1'b0;
      bv1 = bvalid;
      @(posedge clk);
      @(negedge clk);
      bv2 = bvalid;
      br = bresp;
      p2 = wr_pulse;
      @(posedge clk);
      @(negedge clk);
      p3 = wr_pulse;
   endtask

   task automatic rd(input logic [31:0] a, output logic ar1,
                     output logic rv, output logic [31:0] d,
                     output logic [1:0] rr, output logic rv2);
      @(negedge clk);
      araddr = a;
      arvalid = 1'b1;
      rready = 1'b1;
      ar1 = arready;
      @(posedge clk);
      @(negedge clk);
      arvalid = 1'b0;
      rv = rvalid;
      d = rdata;
      rr = rresp;
      @(posedge clk);
      @(negedge clk);
      rv2 = rvalid;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      checks++;
      if ({awready, wready, arready} !== 3'b111) begin
         errors++;
         $display("FAIL reset_ready: got %b expected 111",
                  {awready, wready, arready});
      end
      checks++;
      if ({bvalid, rvalid, bresp, rresp} !== 6'b0) begin
         errors++;
         $display("FAIL reset_resp: got %b expected 000000",
                  {bvalid, rvalid, bresp, rresp});
      end
      checks++;
      if (rdata !== 32'h0 || wr_pulse !== '0) begin
         errors++;
         $display("FAIL reset_rdata_pulse: got %h/%h expected 0/0",
                  rdata, wr_pulse);
      end
      checks++;
      if (reg_q !== m_flat()) begin
         errors++;
         $display("FAIL reset_regs: got %h expected %h", reg_q, m_flat());
      end
   endtask

   task automatic test_basic();
      logic bv1, bv2, ar1, rv, rv2;
      logic [1:0] br, er, rr;
      logic [NR-1:0] p2, p3, ep;
      logic [31:0] d;
      m_write(32'h04, 32'hDEAD_BEEF, 4'hF, er, ep);
      wr(32'h04, 32'hDEAD_BEEF, 4'hF, bv1, bv2, br, p2, p3);
      checks++;
      if ({bv1, bv2} !== 2'b01) begin
         errors++;
         $display("FAIL basic_blat: got %b expected 01", {bv1, bv2});
      end
      checks++;
      if (br !== 2'b00 || p2 !== 16'h0002 || p3 !== 16'h0) begin
         errors++;
         $display("FAIL basic_bresp_pulse: got %b %h %h expected 00 0002 0000",
                  br, p2, p3);
      end
      rd(32'h04, ar1, rv, d, rr, rv2);
      checks++;
      if ({ar1, rv, rv2} !== 3'b110 || d !== 32'hDEAD_BEEF || rr !== 2'b00) begin
         errors++;
         $display("FAIL basic_read: got %b %h %b expected 110 deadbeef 00",
                  {ar1, rv, rv2}, d, rr);
      end
   endtask

   task automatic test_w_first();
      logic bv1, bv2;
      logic [1:0] br, er;
      logic [NR-1:0] p2, p3, ep;
      m_write(32'h08, 32'hAAAA_AAAA, 4'hF, er, ep);
      wr(32'h08, 32'hAAAA_AAAA, 4'hF, bv1, bv2, br, p2, p3);
      m_write(32'h08, 32'h1122_3344, 4'b0101, er, ep);
      @(negedge clk);
      wdata = 32'h1122_3344;
      wstrb = 4'b0101;
      wvalid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      wvalid = 1'b0;
      for (int j = 0; j < 3; j++) begin
         checks++;
         if (wready !== 1'b0 || bvalid !== 1'b0) begin
            errors++;
            $display("FAIL wfirst_hold%0d: got wready=%b bvalid=%b expected 0 0",
                     j, wready, bvalid);
         end
         if (j < 2) begin
            @(posedge clk);
            @(negedge clk);
         end
      end
      awaddr = 32'h08;
      awvalid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      awvalid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || wready !== 1'b1) begin
         errors++;
         $display("FAIL wfirst_b: got %b %b %b expected 1 00 1",
                  bvalid, bresp, wready);
      end
      checks++;
      if (reg_q[2*DW +: DW] !== 32'hAA22_AA44 || reg_q !== m_flat()) begin
         errors++;
         $display("FAIL wfirst_data: got %h expected aa22aa44",
                  reg_q[2*DW +: DW]);
      end
   endtask

   task automatic test_miss();
      logic bv1, bv2, ar1, rv, rv2;
      logic [1:0] br, er, rr;
      logic [NR-1:0] p2, p3, ep;
      logic [31:0] d;
      m_write(32'h40, 32'h5A5A_5A5A, 4'hF, er, ep);
      wr(32'h40, 32'h5A5A_5A5A, 4'hF, bv1, bv2, br, p2, p3);
      checks++;
      if (bv2 !== 1'b1 || br !== 2'b10 || p2 !== '0) begin
         errors++;
         $display("FAIL miss_write: got %b %b %h expected 1 10 0000",
                  bv2, br, p2);
      end
      checks++;
      if (reg_q !== m_flat()) begin
         errors++;
         $display("FAIL miss_regs: got %h expected %h", reg_q, m_flat());
      end
      rd(32'h40, ar1, rv, d, rr, rv2);
      checks++;
      if (rv !== 1'b1 || d !== 32'h0 || rr !== 2'b10) begin
         errors++;
         $display("FAIL miss_read: got %b %h %b expected 1 0 10", rv, d, rr);
      end
   endtask

   task automatic test_ro();
      logic bv1, bv2;
      logic [1:0] br, er;
      logic [NR-1:0] p2, p3, ep;
      hw[3*DW +: DW] = 32'h0000_CAFE;
      m_write(32'h0C, 32'hFFFF_FFFF, 4'hF, er, ep);
      wr(32'h0C, 32'hFFFF_FFFF, 4'hF, bv1, bv2, br, p2, p3);
      checks++;
      if (br !== 2'b00 || p2 !== '0 || reg_q !== m_flat()) begin
         errors++;
         $display("FAIL ro_write: got %b %h expected 00 0000 regs unchanged",
                  br, p2);
      end
      @(negedge clk);
      araddr = 32'h0C;
      arvalid = 1'b1;
      rready = 1'b1;
      @(posedge clk);
      #1 hw[3*DW +: DW] = 32'h0000_BEEF;
      @(negedge clk);
      arvalid = 1'b0;
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'h0000_CAFE || rresp !== 2'b00) begin
         errors++;
         $display("FAIL ro_read: got %b %h %b expected 1 0000cafe 00",
                  rvalid, rdata, rresp);
      end
   endtask

   task automatic test_bstall();
      logic [1:0] er1, er2;
      logic [NR-1:0] ep;
      m_write(32'h10, 32'h1234_5678, 4'hF, er1, ep);
      m_write(32'h44, 32'h9999_0000, 4'hF, er2, ep);
      @(negedge clk);
      awaddr = 32'h10;
      wdata = 32'h1234_5678;
      wstrb = 4'hF;
      awvalid = 1'b1;
      wvalid = 1'b1;
      bready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      awaddr = 32'h44;
      wdata = 32'h9999_0000;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bvalid !== 1'b1 || bresp !== er1) begin
         errors++;
         $display("FAIL bstall_first: got %b %b expected 1 %b",
                  bvalid, bresp, er1);
      end
      @(posedge clk);
      @(negedge clk);
      awvalid = 1'b0;
      wvalid = 1'b0;
      for (int j = 0; j < 5; j++) begin
         checks++;
         if ({bvalid, bresp, awready, wready} !== {1'b1, er1, 2'b00}) begin
            errors++;
            $display("FAIL bstall_hold%0d: got %b expected %b", j,
                     {bvalid, bresp, awready, wready}, {1'b1, er1, 2'b00});
         end
         @(posedge clk);
         @(negedge clk);
      end
      checks++;
      if (reg_q !== m_flat()) begin
         errors++;
         $display("FAIL bstall_regs: got %h expected %h", reg_q, m_flat());
      end
      bready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bvalid !== 1'b1 || bresp !== er2) begin
         errors++;
         $display("FAIL bstall_second: got %b %b expected 1 %b",
                  bvalid, bresp, er2);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bvalid !== 1'b0 || awready !== 1'b1) begin
         errors++;
         $display("FAIL bstall_drain: got %b %b expected 0 1",
                  bvalid, awready);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      awaddr = 32'h14;
      awvalid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      awvalid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_reset();
      checks++;
      if (awready !== 1'b1 || bvalid !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_flags: got %b %b expected 1 0",
                  awready, bvalid);
      end
      wdata = 32'h7777_7777;
      wstrb = 4'hF;
      wvalid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      wvalid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (bvalid !== 1'b0 || wready !== 1'b0 || reg_q !== m_flat()) begin
         errors++;
         $display("FAIL rstmid_nowrite: got %b %b %h expected 0 0 %h",
                  bvalid, wready, reg_q, m_flat());
      end
      do_reset();
   endtask

   task automatic test_collision();
      logic [31:0] old;
      logic [1:0] er;
      logic [NR-1:0] ep;
      old = mdl[6];
      m_write(32'h18, 32'hC0DE_F00D, 4'hF, er, ep);
      @(negedge clk);
      awaddr = 32'h18;
      wdata = 32'hC0DE_F00D;
      wstrb = 4'hF;
      awvalid = 1'b1;
      wvalid = 1'b1;
      bready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      awvalid = 1'b0;
      wvalid = 1'b0;
      araddr = 32'h18;
      arvalid = 1'b1;
      rready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      arvalid = 1'b0;
      checks++;
      if (rvalid !== 1'b1 || rdata !== old || bvalid !== 1'b1) begin
         errors++;
         $display("FAIL collision: got %b %h %b expected 1 %h 1",
                  rvalid, rdata, bvalid, old);
      end
      checks++;
      if (reg_q !== m_flat()) begin
         errors++;
         $display("FAIL collision_regs: got %h expected %h", reg_q, m_flat());
      end
   endtask

   task automatic test_random();
      logic bv1, bv2, ar1, rv, rv2;
      logic [1:0] br, er, rr, err;
      logic [NR-1:0] p2, p3, ep;
      logic [31:0] a, d, ed;
      logic [3:0] s;
      for (int n = 0; n < 60; n++) begin
         a = ($urandom_range(0, 19) * 4) + $urandom_range(0, 3);
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            m_write(a, d, s, er, ep);
            wr(a, d, s, bv1, bv2, br, p2, p3);
            checks++;
            if ({bv1, bv2, br} !== {2'b01, er} || p2 !== ep || p3 !== '0) begin
               errors++;
               $display("FAIL rnd_wr a=%h: got %b %h %h expected %b %h 0",
                        a, {bv1, bv2, br}, p2, p3, {2'b01, er}, ep);
            end
            checks++;
            if (reg_q !== m_flat()) begin
               errors++;
               $display("FAIL rnd_regs a=%h: got %h expected %h",
                        a, reg_q, m_flat());
            end
         end else begin
            for (int i = 0; i < NR; i++) hw[i*DW +: DW] = $urandom;
            m_read(a, ed, err);
            rd(a, ar1, rv, d, rr, rv2);
            checks++;
            if ({ar1, rv, rv2} !== 3'b110 || d !== ed || rr !== err) begin
               errors++;
               $display("FAIL rnd_rd a=%h: got %b %h %b expected 110 %h %b",
                        a, {ar1, rv, rv2}, d, rr, ed, err);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      awaddr = '0;
      awprot = '0;
      awvalid = 1'b0;
      wdata = '0;
      wstrb = '0;
      wvalid = 1'b0;
      bready = 1'b1;
      araddr = '0;
      arprot = '0;
      arvalid = 1'b0;
      rready = 1'b1;
      hw = '0;
      test_reset();
      test_basic();
      test_w_first();
      test_miss();
      test_ro();
      test_bstall();
      test_reset_mid();
      test_collision();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
